// File: rtl/imhotep_pkg.sv
// Shared processor package: operation encodings, the widths used across
// the core, and the load/store unit FSM state encoding.
package imhotep_pkg;

  localparam int XLEN                = 32;
  localparam int RAM_WIDTH           = 16;
  localparam int LSU_TIMEOUT_CYC_DEF = 64;

  typedef enum logic [3:0] {
    LSU_NOP = 4'd0,
    LSU_LB  = 4'd1,
    LSU_LH  = 4'd2,
    LSU_LW  = 4'd3,
    LSU_LBU = 4'd4,
    LSU_LHU = 4'd5,
    LSU_SB  = 4'd6,
    LSU_SH  = 4'd7,
    LSU_SW  = 4'd8
  } op_lsu_e;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_RESP = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_ctrl_if.sv
// Memory-side bus of the load/store unit. The LSU is the master; the
// memory (or bench model) is the slave.
interface lsu_ctrl_if
  import imhotep_pkg::*;
#(
  parameter int ADDR_W = RAM_WIDTH,
  parameter int DATA_W = XLEN
);
  localparam int NB = DATA_W / 8;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [NB-1:0]     mem_be_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_err_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic for the LSU: legality/alignment decode, byte
// enables, store data lane shift and load data extract/extend.
module lsu_align
  import imhotep_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int NB     = DATA_W / 8,
  parameter int OFF_W  = $clog2(NB)
) (
  input  op_lsu_e           op,
  input  logic [OFF_W-1:0]  offset,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [NB-1:0]     be,
  output logic [DATA_W-1:0] wdata_lane,
  output logic [DATA_W-1:0] rdata_ext,
  output logic              legal,
  output logic              is_mem,
  output logic              is_store
);

  logic [NB-1:0]           be_base;
  logic [DATA_W-1:0]       rdata_shift;
  logic [OFF_W+2:0]        bit_off;

  assign bit_off     = {offset, 3'b000};
  assign wdata_lane  = wdata << bit_off;
  assign rdata_shift = rdata >> bit_off;
  assign be          = be_base << offset;

  // Access size, natural-alignment check and load/store classification.
  always_comb begin
    be_base  = '0;
    legal    = 1'b0;
    is_mem   = 1'b0;
    is_store = 1'b0;
    case (op)
      LSU_NOP: legal = 1'b1;
      LSU_LB, LSU_LBU, LSU_SB: begin
        be_base  = NB'(1);
        legal    = 1'b1;
        is_mem   = 1'b1;
        is_store = (op == LSU_SB);
      end
      LSU_LH, LSU_LHU, LSU_SH: begin
        be_base  = NB'(3);
        legal    = (offset[0] == 1'b0);
        is_mem   = 1'b1;
        is_store = (op == LSU_SH);
      end
      LSU_LW, LSU_SW: begin
        be_base  = NB'(15);
        legal    = (offset[1:0] == 2'b00);
        is_mem   = 1'b1;
        is_store = (op == LSU_SW);
      end
      default: ;
    endcase
  end

  // Load result: lane already moved to bit 0, now sign- or zero-extend.
  always_comb begin
    rdata_ext = '0;
    case (op)
      LSU_LB:  rdata_ext = {{(DATA_W-8){rdata_shift[7]}}, rdata_shift[7:0]};
      LSU_LBU: rdata_ext[7:0] = rdata_shift[7:0];
      LSU_LH:  rdata_ext = {{(DATA_W-16){rdata_shift[15]}}, rdata_shift[15:0]};
      LSU_LHU: rdata_ext[15:0] = rdata_shift[15:0];
      LSU_LW:  rdata_ext[31:0] = rdata_shift[31:0];
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one transaction in flight, IDLE/REQ/WAIT/RESP.
// Optional watchdog enabled by defining LSU_TIMEOUT_EN; without it a
// transaction waits indefinitely for grant and response.
module lsu_ctrl
  import imhotep_pkg::*;
#(
  parameter int ADDR_W      = RAM_WIDTH,
  parameter int DATA_W      = XLEN,
  parameter int TIMEOUT_CYC = LSU_TIMEOUT_CYC_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  op_lsu_e           op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o,
  lsu_ctrl_if.master        mem
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  lsu_state_e        state, next_state;
  op_lsu_e           op_q, op_sel;
  logic [OFF_W-1:0]  off_q, off_sel;
  logic [ADDR_W-1:0] addr_q;
  logic [NB-1:0]     be_q, be;
  logic [DATA_W-1:0] wdata_q, wdata_lane, rdata_ext, rdata_q;
  logic              we_q, err_q;
  logic              legal, is_mem, is_store;
  logic              accept, direct, timeout;

  // While idle the lane logic looks at the incoming request; afterwards it
  // works on the registered transaction so the load extract uses the
  // offset that was captured at accept time.
  assign op_sel  = (state == LSU_IDLE) ? op_i : op_q;
  assign off_sel = (state == LSU_IDLE) ? addr_i[OFF_W-1:0] : off_q;

  lsu_align #(.DATA_W(DATA_W), .NB(NB), .OFF_W(OFF_W)) u_align (
    .op         (op_sel),
    .offset     (off_sel),
    .wdata      (wdata_i),
    .rdata      (mem.mem_rdata_i),
    .be         (be),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext),
    .legal      (legal),
    .is_mem     (is_mem),
    .is_store   (is_store)
  );

  assign accept = req_i && (state == LSU_IDLE);
  assign direct = !(legal && is_mem);

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] tmo_cnt;

  // Watchdog: zero outside REQ/WAIT, so it restarts on every entry to REQ.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_cnt <= '0;
    end else if (state == LSU_REQ || state == LSU_WAIT) begin
      tmo_cnt <= tmo_cnt + CNT_W'(1);
    end else begin
      tmo_cnt <= '0;
    end
  end

  assign timeout = (state == LSU_REQ || state == LSU_WAIT) &&
                   (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= LSU_IDLE;
    else         state <= next_state;
  end

  // Next-state logic; response beats only count while in WAIT.
  always_comb begin
    next_state = state;
    case (state)
      LSU_IDLE: if (accept) next_state = direct ? LSU_RESP : LSU_REQ;
      LSU_REQ: begin
        if (timeout)            next_state = LSU_RESP;
        else if (mem.mem_gnt_i) next_state = LSU_WAIT;
      end
      LSU_WAIT: if (mem.mem_rvalid_i || timeout) next_state = LSU_RESP;
      LSU_RESP: next_state = LSU_IDLE;
      default:  next_state = LSU_IDLE;
    endcase
  end

  // State-decoded handshake outputs.
  always_comb begin
    ready_o       = (state == LSU_IDLE);
    valid_o       = (state == LSU_RESP);
    mem.mem_req_o = (state == LSU_REQ);
  end

  assign mem.mem_we_o    = we_q;
  assign mem.mem_addr_o  = addr_q;
  assign mem.mem_be_o    = be_q;
  assign mem.mem_wdata_o = wdata_q;
  assign rdata_o         = rdata_q;
  assign err_o           = err_q;

  // Transaction capture at accept, and result capture on the way into RESP.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q    <= LSU_NOP;
      off_q   <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        LSU_IDLE: if (accept) begin
          op_q    <= op_i;
          off_q   <= addr_i[OFF_W-1:0];
          addr_q  <= {addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          be_q    <= be;
          we_q    <= is_store;
          wdata_q <= wdata_lane;
          if (direct) begin
            rdata_q <= '0;
            err_q   <= !legal;
          end
        end
        LSU_REQ: if (timeout) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
        LSU_WAIT: begin
          if (mem.mem_rvalid_i) begin
            rdata_q <= we_q ? '0 : rdata_ext;
            err_q   <= mem.mem_err_i;
          end else if (timeout) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
